dense_layer_mac_engine: RTL

Parametrised fully-connected layer engine computing out = W·x (optionally leaky-ReLU activated) for any IN_SIZE×OUT_SIZE weight matrix using LANES time-shared MAC lanes. It generalises the fixed 20→10 layer-2 multiplier. It sits between consecutive layer stages of the Semeion classifier pipeline and replaces per-layer hand-instantiated multipliers. It adds a ready/valid handshake on both sides, signed arithmetic, multi-pass row scheduling and an optional fused activation.

---
 rtl/nn_accel_pkg.sv | 32 +++
 rtl/dense_layer_mac_engine_mac_lane.sv | 42 ++++
 rtl/dense_layer_mac_engine.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/nn_accel_pkg.sv
// Shared types and helpers for the neural-network layer stages.
// Provides the layer FSM state enum, accumulator sizing and leaky ReLU.
package nn_accel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ACT,
    DONE
  } state_t;

  // Widest accumulator the activation helper handles.
  localparam int ACT_MAX_W = 128;

  function automatic int acc_width(
    input int dw,
    input int ww,
    input int n
  );
    return dw + ww + $clog2(n);
  endfunction

  function automatic logic signed [ACT_MAX_W-1:0] leaky_relu(
    input logic signed [ACT_MAX_W-1:0] v,
    input bit                          en,
    input int                          sh
  );
    if (en && v < 0) return v >>> sh;
    return v;
  endfunction

endpackage

// File: rtl/dense_layer_mac_engine_mac_lane.sv
// mac_lane: signed multiply-accumulate lane with clear, enable and mask.
// Ports: clk, reset, i_clr, i_en, i_mask, i_x, i_w in; o_sum (acc + x*w) out.
module mac_lane
  import nn_accel_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 45
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_clr,
  input  logic                       i_en,
  input  logic                       i_mask,
  input  logic signed [DATA_W-1:0]   i_x,
  input  logic signed [WEIGHT_W-1:0] i_w,
  output logic signed [ACC_W-1:0]    o_sum
);

  localparam int PW = DATA_W + WEIGHT_W;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_sum;

  // Both operands widened first so the product is exact.
  assign w_prod = PW'(i_x) * PW'(i_w);
  assign w_sum  = r_acc + ACC_W'(w_prod);
  assign o_sum  = w_sum;

  // Clear wins: on a row's last element the sum leaves via o_sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en && !i_mask) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/dense_layer_mac_engine.sv
// Fully-connected layer: out = W*x with LANES time-shared MAC lanes,
// optional leaky ReLU, ready/valid on input and output.
// Ports: clk, reset (sync, high); in_valid/in_ready/in_data;
// out_valid/out_ready/out_data (row r at [r*ACC_W +: ACC_W]); busy.
// WEIGHT_INIT holds the weight image, W[r][c] at element r*IN_SIZE+c.
module dense_layer_mac_engine
  import nn_accel_pkg::*;
#(
  parameter int IN_SIZE     = 20,
  parameter int OUT_SIZE    = 10,
  parameter int LANES       = 5,
  parameter int DATA_W      = 32,
  parameter int WEIGHT_W    = 8,
  parameter int ACC_W       = acc_width(DATA_W, WEIGHT_W, IN_SIZE),
  parameter bit ACT_EN      = 1'b0,
  parameter int LEAKY_SHIFT = 3,
  parameter logic [OUT_SIZE*IN_SIZE*WEIGHT_W-1:0] WEIGHT_INIT = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_SIZE*DATA_W-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_SIZE*ACC_W-1:0]   out_data,
  output logic                        busy
);

  localparam int PASSES = (OUT_SIZE + LANES - 1) / LANES;
  localparam int AW     = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int NW     = OUT_SIZE * IN_SIZE;
  localparam int RW     = (NW > 1) ? $clog2(NW) : 1;

  state_t r_state;
  state_t w_next;

  logic [AW-1:0] r_addr;
  logic [PW-1:0] r_pass;

  logic signed [DATA_W-1:0]   r_x [IN_SIZE];
  logic signed [WEIGHT_W-1:0] w_rom [NW];
  logic signed [ACC_W-1:0]    w_sum [LANES];

  logic w_accept;
  logic w_run;
  logic w_last;
  logic w_final;
  logic w_clr;

  assign in_ready  = (r_state == IDLE) && !reset;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);

  assign w_accept = in_valid && in_ready;
  assign w_run    = (r_state == RUN);
  assign w_last   = (r_addr == AW'(IN_SIZE - 1));
  assign w_final  = w_last && (r_pass == PW'(PASSES - 1));
  assign w_clr    = w_accept || (w_run && w_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_final) w_next = ACT;
      ACT:     w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_pass <= '0;
    end else if (w_accept) begin
      r_addr <= '0;
      r_pass <= '0;
    end else if (w_run) begin
      if (w_last) begin
        r_addr <= '0;
        r_pass <= w_final ? '0 : r_pass + PW'(1);
      end else begin
        r_addr <= r_addr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < IN_SIZE; c++) r_x[c] <= '0;
    end else if (w_accept) begin
      for (int c = 0; c < IN_SIZE; c++)
        r_x[c] <= in_data[c*DATA_W +: DATA_W];
    end
  end

  for (genvar i = 0; i < NW; i++) begin : g_rom
    assign w_rom[i] = WEIGHT_INIT[i*WEIGHT_W +: WEIGHT_W];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [31:0]                w_row;
    logic                       w_mask;
    logic [RW-1:0]              w_idx;
    logic signed [WEIGHT_W-1:0] w_w;

    assign w_row  = 32'(r_pass) * 32'(LANES) + 32'(l);
    // Lanes past the last row only occur in the final pass.
    assign w_mask = (w_row >= 32'(OUT_SIZE));
    assign w_idx  = w_mask ? '0
                  : RW'(w_row * 32'(IN_SIZE) + 32'(r_addr));
    assign w_w    = w_rom[w_idx];

    mac_lane #(
      .DATA_W  (DATA_W),
      .WEIGHT_W(WEIGHT_W),
      .ACC_W   (ACC_W)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_clr),
      .i_en  (w_run),
      .i_mask(w_mask),
      .i_x   (r_x[r_addr]),
      .i_w   (w_w),
      .o_sum (w_sum[l])
    );
  end

  // Each row owns its result slot and output register, so the
  // buffer write is a fixed lane-to-row mux per pass.
  for (genvar r = 0; r < OUT_SIZE; r++) begin : g_row
    localparam int P = r / LANES;
    localparam int L = r % LANES;

    logic signed [ACC_W-1:0] r_res;
    logic signed [ACC_W-1:0] r_out;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_res <= '0;
      end else if (w_run && w_last && r_pass == PW'(P)) begin
        r_res <= w_sum[L];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_out <= '0;
      end else if (r_state == ACT) begin
        r_out <= ACC_W'(leaky_relu(ACT_MAX_W'(r_res),
                                   ACT_EN, LEAKY_SHIFT));
      end
    end

    assign out_data[r*ACC_W +: ACC_W] = r_out;
  end

endmodule
